// File: rtl/instr_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_mem_loader: instruction ROM/RAM with a byte-stream program loader.  |
// | Optional macro INSTR_MEM_ILLOP_EN: out-of-range PC reads FFFFFFFF.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_mem_loader #(
  parameter int DEPTH = 128,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] PC,
  output logic [31:0]     Instruct,
  input  logic            load_start,
  input  logic            rx_valid,
  input  logic [7:0]      rx_byte,
  output logic            busy,
  output logic            load_done,
  output logic            load_err,
  output logic            pc_oor
);

  localparam int AW = $clog2(DEPTH);
`ifdef INSTR_MEM_ILLOP_EN
  localparam logic [31:0] OOR_WORD = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OOR_WORD = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [7:0]    n_hi;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [23:0]   word_sr;
  logic [15:0]   hdr_n;
  logic [31:0]   wr_word;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic          unused_pc;

  assign hdr_n     = {n_hi, rx_byte};
  assign wr_word   = {word_sr, rx_byte};
  assign rd_idx    = PC[AW+1:2];
  assign unused_pc = ^PC[1:0];
  // The write happens on the 4th byte itself, so it must see the same
  // priority (reset, then restart) as the FSM does.
  assign wr_en = !reset && !load_start && rx_valid && (state == DATA) && (lane == 2'd3);

  generate
    if (PC_W > AW + 2) begin : g_oor
      assign pc_oor = |PC[PC_W-1:AW+2];
    end else begin : g_no_oor
      assign pc_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      widx      <= '0;
      lane      <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      n_hi      <= '0;
      last_idx  <= '0;
      word_sr   <= '0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state    <= HDR_HI;
        busy     <= 1'b1;
        lane     <= '0;
        widx     <= '0;
        load_err <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
          end
          HDR_HI: begin
            n_hi  <= rx_byte;
            state <= HDR_LO;
          end
          HDR_LO: begin
            if (hdr_n > 16'(DEPTH)) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else if (hdr_n == 16'd0) begin
              load_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              // Store N-1 so the last-word test fits in AW bits even for N=DEPTH.
              last_idx <= AW'(hdr_n - 16'd1);
              state    <= DATA;
            end
          end
          DATA: begin
            lane    <= lane + 2'd1;
            word_sr <= {word_sr[15:0], rx_byte};
            if (lane == 2'd3) begin
              if (widx == last_idx) begin
                load_done <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                widx <= widx + AW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= wr_word;
    end
  end

  always_comb begin
    Instruct = 32'h0;
    if (reset || busy) begin
      Instruct = 32'h0;
    end else if (pc_oor) begin
      Instruct = OOR_WORD;
    end else begin
      Instruct = mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// Bench for instr_mem_loader: byte-queue model of the load protocol checked
// every cycle, plus hand-computed literal expectations.
module tb_instr_mem_loader;

  localparam int DEPTH = 128;
  localparam int PC_W  = 32;
`ifdef INSTR_MEM_ILLOP_EN
  localparam logic [31:0] OOR_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OOR_EXP = 32'h0000_0000;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] PC;
  logic [31:0]     Instruct;
  logic            load_start;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            busy;
  logic            load_done;
  logic            load_err;
  logic            pc_oor;

  instr_mem_loader #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instruct(Instruct),
    .load_start(load_start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .busy(busy), .load_done(load_done), .load_err(load_err), .pc_oor(pc_oor)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the bytes received since the last load_start, interpreted as
  // header + words; memory is only compared where the model has written it.
  logic [31:0] mm [DEPTH];
  bit          kn [DEPTH];
  logic [7:0]  q [$];
  bit          armed = 0;
  bit          m_busy = 0, m_done = 0, m_err = 0;
  int          m_n = 0;
  int          w;
  int          k;

  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      armed = 1; m_busy = 0; m_err = 0; q.delete();
    end else if (load_start) begin
      m_busy = 1; m_err = 0; q.delete();
    end else if (rx_valid && m_busy) begin
      q.push_back(rx_byte);
      k = q.size() - 2;
      if (k == 0) begin
        m_n = {q[0], q[1]};
        if (m_n > DEPTH) begin m_err = 1; m_busy = 0; end
        else if (m_n == 0) begin m_done = 1; m_busy = 0; end
      end else if (k > 0 && k % 4 == 0) begin
        w = k / 4 - 1;
        mm[w] = {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]};
        kn[w] = 1;
        if (w + 1 == m_n) begin m_done = 1; m_busy = 0; end
      end
    end
  end

  logic        e_oor;
  int          e_idx;
  logic [31:0] e_ins;

  always @(negedge clk) begin
    if (armed) begin
      if (load_done === 1'b1) done_cnt++;
      e_oor = (PC >= 32'(4 * DEPTH));
      e_idx = int'(PC >> 2) % DEPTH;
      e_ins = (reset || m_busy) ? 32'h0 : (e_oor ? OOR_EXP : mm[e_idx]);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_err", 32'(load_err), 32'(m_err));
      chk("pc_oor", 32'(pc_oor), 32'(e_oor));
      if (reset || m_busy || e_oor || kn[e_idx]) chk("Instruct", Instruct, e_ins);
    end
  end

  task automatic step(input logic r, input logic ls, input logic v, input logic [7:0] b);
    reset = r; load_start = ls; rx_valid = v; rx_byte = b;
    @(posedge clk); #1;
    reset = 0; load_start = 0; rx_valid = 0;
  endtask
  task automatic send(input logic [7:0] b); step(0, 0, 1, b); endtask
  task automatic start(); step(0, 1, 0, 8'h00); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00); endtask
  task automatic send4(input logic [31:0] x, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send(x[i*8 +: 8]);
      if (gap) idle(1);
    end
  endtask
  task automatic rd(input string nm, input logic [31:0] pc_v, input logic [31:0] exp);
    PC = pc_v; #1;
    chk(nm, Instruct, exp);
  endtask

  function automatic logic [31:0] fw(input int i);
    logic [7:0] b = 8'(i);
    return {8'hC0, b, 8'h5A, ~b};
  endfunction

  int c0;

  initial begin
    PC = '0; reset = 1; load_start = 0; rx_valid = 0; rx_byte = 0;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(load_err), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    step(0, 0, 1, 8'h55);          // rx_valid in IDLE is ignored
    chk("idle_rx_busy", 32'(busy), 32'h0);

    // basic load
    start();
    send(8'h00); send(8'h02);
    send4(32'h24020001, 0);
    send4(32'h00000000, 0);
    chk("basic_done", 32'(load_done), 32'h1);
    chk("basic_busy", 32'(busy), 32'h0);
    rd("basic_pc0", 32'h0, 32'h24020001);
    rd("basic_pc4", 32'h4, 32'h00000000);
    idle(1);

    // oversize header
    start();
    send(8'h00); send(8'h81);
    chk("over_err", 32'(load_err), 32'h1);
    chk("over_busy", 32'(busy), 32'h0);
    rd("over_pc0", 32'h0, 32'h24020001);
    idle(1);
    chk("over_sticky", 32'(load_err), 32'h1);
    start();
    chk("over_clr", 32'(load_err), 32'h0);
    step(1, 0, 0, 8'h00);

    // restart mid-word
    c0 = done_cnt;
    start();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    start();
    send(8'h00); send(8'h01);
    send4(32'h11223344, 0);
    idle(2);
    chk("restart_done_cnt", 32'(done_cnt - c0), 32'h1);
    rd("restart_pc0", 32'h0, 32'h11223344);

    // reset mid-load
    c0 = done_cnt;
    start();
    send(8'h00); send(8'h01); send(8'hDE); send(8'hAD);
    step(1, 0, 0, 8'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    idle(3);
    chk("midrst_no_done", 32'(done_cnt - c0), 32'h0);
    rd("midrst_pc0", 32'h0, 32'h11223344);

    // gapped 3-word load
    start(); idle(1);
    send(8'h00); idle(1); send(8'h03); idle(1);
    send4(32'h01020304, 1);
    send4(32'hA5A5F00F, 1);
    send4(32'hDEADBEEF, 1);
    rd("gap_pc0", 32'h0, 32'h01020304);
    rd("gap_pc4", 32'h4, 32'hA5A5F00F);
    rd("gap_pc8", 32'h8, 32'hDEADBEEF);

    // zero-length load
    start();
    send(8'h00); send(8'h00);
    chk("n0_done", 32'(load_done), 32'h1);
    chk("n0_busy", 32'(busy), 32'h0);
    rd("n0_pc0", 32'h0, 32'h01020304);

    // full-depth load (N = DEPTH)
    start();
    send(8'h00); send(8'(DEPTH));
    for (int i = 0; i < DEPTH; i++) send4(fw(i), 0);
    chk("full_done", 32'(load_done), 32'h1);
    rd("full_last", 32'h1FC, 32'hC07F5A80);
    rd("full_first", 32'h0, 32'hC0005AFF);
    chk("full_last_oor", 32'(pc_oor), 32'h0);

    // out of range
    rd("oor_instr", 32'h200, OOR_EXP);
    chk("oor_flag", 32'(pc_oor), 32'h1);
    idle(2);
    rd("oor_high", 32'h8000_0000, OOR_EXP);
    idle(2);
    PC = '0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit instruction words; power of two, 16..4096.
REQ-002 SHALL have parameter PC_W, default 32, width of the byte-address PC input.
REQ-003 SHALL derive AW = log2(DEPTH) internally as the word-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port PC, input, PC_W bits: byte address; word index = PC[AW+1:2].
REQ-007 SHALL have port Instruct, output, 32 bits: instruction at PC (combinational read).
REQ-008 SHALL have port load_start, input, 1 bit: one-cycle pulse that begins a program load.
REQ-009 SHALL have port rx_valid, input, 1 bit: qualifies rx_byte for one cycle.
REQ-010 SHALL have port rx_byte, input, 8 bits: loader byte stream.
REQ-011 SHALL have port busy, output, 1 bit: high while a load is in progress; the CPU holds its PC on this.
REQ-012 SHALL have port load_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-013 SHALL have port load_err, output, 1 bit: sticky error, cleared by load_start or reset.
REQ-014 SHALL have port pc_oor, output, 1 bit: combinational; high when PC[PC_W-1:AW+2] != 0.

Function
REQ-015 SHALL make Instruct = mem[PC[AW+1:2]] when reset=0, busy=0 and pc_oor=0.
REQ-016 SHALL make Instruct = 0 (nop) whenever reset=1 or busy=1.
REQ-017 SHALL implement FSM states IDLE, HDR_HI, HDR_LO, DATA.
- IDLE -> HDR_HI on load_start.
- HDR_HI -> HDR_LO on rx_valid; the byte is N[15:8].
- HDR_LO -> DATA on rx_valid; the byte is N[7:0].
REQ-018 SHALL, in HDR_LO on rx_valid: if N > DEPTH, set load_err and go to IDLE with no writes; if N = 0, pulse load_done and go to IDLE.
REQ-019 SHALL, in DATA, assemble each word from 4 bytes MSB first and write it to mem[widx] in the same cycle as its 4th valid byte; widx starts at 0 and increments by 1 per word.
REQ-020 SHALL, after the N-th word is written, go to IDLE and pulse load_done in the following cycle; busy falls in that same cycle.
REQ-021 SHALL assert busy = 1 in HDR_HI, HDR_LO and DATA, and 0 in IDLE.
REQ-022 SHALL ignore rx_valid in IDLE.
REQ-023 SHALL ignore cycles with rx_valid=0 in every state; there is no timeout.
REQ-024 SHALL, on load_start in any non-IDLE state, restart: go to HDR_HI, clear the byte lane and widx, clear load_err; already written words remain.
REQ-025 SHALL never write an address >= N and never wrap widx.

Reset
REQ-026 SHALL, on reset, set the FSM to IDLE, widx = 0, byte lane = 0, busy = 0, load_done = 0, load_err = 0.
REQ-027 SHALL leave memory contents unchanged by reset; no load_done is issued after a reset mid-load.
REQ-028 SHALL give reset priority over load_start and rx_valid in the same cycle.

Configuration
REQ-029 SHALL use macro INSTR_MEM_ILLOP_EN.
- Defined: Instruct = 32'hFFFFFFFF (exception word) when pc_oor=1, busy=0 and reset=0.
- Undefined: Instruct = 0 (nop) in that case.
- pc_oor behaves identically in both builds.

Verification
REQ-030 SHALL cover basic load (DEPTH=128): load_start, then bytes 00 02 24 02 00 01 00 00 00 00 -> mem[0]=24020001, mem[1]=0; load_done one cycle after the last byte; then PC=0 -> Instruct=24020001, PC=4 -> 00000000.
REQ-031 SHALL cover oversize header: header 00 81 with DEPTH=128 -> load_err=1, busy=0 next cycle, mem[0] unchanged; the next load_start clears load_err.
REQ-032 SHALL cover restart: load_start, header 00 01, bytes AA BB, then load_start, header 00 01, bytes 11 22 33 44 -> mem[0]=11223344, exactly one load_done.
REQ-033 SHALL cover reset mid-load: reset after 2 of 4 data bytes -> busy=0, no load_done, mem[0] keeps its previous value.
REQ-034 SHALL cover out of range: PC=0x200 with DEPTH=128 -> pc_oor=1; Instruct=FFFFFFFF with INSTR_MEM_ILLOP_EN, 00000000 without.
REQ-035 SHALL cover gapped stream: idle cycles (rx_valid=0) between every byte of a 3-word load -> identical memory contents; busy=1 throughout and Instruct=0 throughout.
